blk_d45685: RTL and testbench

Parametrised successor to the passive OCI test-bench monitor.
- Captures debug compressed-trace (DCT) words from the Nios II OCI into an internal FIFO.
- Exposes them on a valid/ready read port.
- Tracks overflow, drop count and fill level.
- Sequences end-of-test: flushes the buffer, then asserts a completion flag the bench or host can poll.

---
 rtl/medidor_desempenho_oci_pkg.sv | 19 +
 rtl/blk_d45685_if.sv | 23 ++
 rtl/medidor_desempenho_oci_sync_fifo.sv | 70 +++++++
 rtl/blk_d45685.sv | 109 ++++++++++
 tb/tb_blk_d45685.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/medidor_desempenho_oci_pkg.sv
// rtl/medidor_desempenho_oci_pkg.sv - shared types and constants for the OCI trace capture block
// Entry width depends on MEDIDOR_OCI_TRACE_TSTAMP_EN (timestamp prepended when defined).
package medidor_desempenho_oci_pkg;

    localparam int DCT_W_DEF = 30;
    localparam int CNT_W_DEF = 4;
    localparam int TS_W_DEF  = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int entry_width(int dct_w, int cnt_w, int ts_w, bit ts_en);
        return dct_w + cnt_w + (ts_en ? ts_w : 0);
    endfunction

endpackage

// File: rtl/blk_d45685_if.sv
// rtl/blk_d45685_if.sv - trace capture stream interface (DCT input side and read port)
interface blk_d45685_if #(
    parameter int DCT_W   = 30,
    parameter int CNT_W   = 4,
    parameter int ENTRY_W = 34
);
    logic               dct_valid;
    logic [DCT_W-1:0]   dct_buffer;
    logic [CNT_W-1:0]   dct_count;
    logic [ENTRY_W-1:0] rd_data;
    logic               rd_valid;
    logic               rd_ready;

    modport master (
        output dct_valid, dct_buffer, dct_count, rd_ready,
        input  rd_data, rd_valid
    );

    modport slave (
        input  dct_valid, dct_buffer, dct_count, rd_ready,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/medidor_desempenho_oci_sync_fifo.sv
// rtl/medidor_desempenho_oci_sync_fifo.sv - synchronous FIFO with a registered head entry
// Head is held in rd_data so nothing falls through combinationally from push to read port.
module medidor_desempenho_oci_sync_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             rd_ready,
    output logic [W-1:0]     rd_data,
    output logic             rd_valid,
    output logic [LVL_W-1:0] level,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nx;
    logic             pop;

    assign pop       = rd_valid && rd_ready;
    assign full      = (level == LVL_W'(DEPTH));
    assign rd_ptr_nx = rd_ptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr_nx;

            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase

            // Refill the head register from storage, or straight from the writer when storage is empty
            if (pop) begin
                if (level > LVL_W'(1)) begin
                    rd_data  <= mem[rd_ptr_nx];
                    rd_valid <= 1'b1;
                end else if (push) begin
                    rd_data  <= wdata;
                    rd_valid <= 1'b1;
                end else begin
                    rd_valid <= 1'b0;
                end
            end else if (push && !rd_valid) begin
                rd_data  <= wdata;
                rd_valid <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/blk_d45685.sv
// rtl/blk_d45685.sv - OCI trace capture: qualification, drop accounting, end-of-test FSM
// Define MEDIDOR_OCI_TRACE_TSTAMP_EN to prepend a free-running cycle timestamp to each entry.
module blk_d45685
    import medidor_desempenho_oci_pkg::*;
#(
    parameter int DCT_W  = DCT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16,
    parameter int TS_W   = TS_W_DEF,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    blk_d45685_if.slave       bus,
    input  logic              test_ending,
    input  logic              restart,
    output logic [LVL_W-1:0]  level,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count,
    output logic              test_has_ended
);
`ifdef MEDIDOR_OCI_TRACE_TSTAMP_EN
    localparam int ENTRY_W = entry_width(DCT_W, CNT_W, TS_W, 1'b1);
    logic [TS_W-1:0]    ts;
    logic [ENTRY_W-1:0] entry;

    always_ff @(posedge clk) begin
        if (reset) ts <= '0;
        else       ts <= ts + TS_W'(1);
    end

    assign entry = {ts, bus.dct_count, bus.dct_buffer};
`else
    localparam int ENTRY_W = entry_width(DCT_W, CNT_W, TS_W, 1'b0);
    logic [ENTRY_W-1:0] entry;

    assign entry = {bus.dct_count, bus.dct_buffer};
`endif

    state_t             state;
    logic               capture;
    logic               pop;
    logic               push;
    logic               drop;
    logic               full;
    logic               fifo_valid;
    logic [ENTRY_W-1:0] fifo_data;

    assign capture = (state == RUN) && bus.dct_valid && (bus.dct_count != '0);
    assign pop     = fifo_valid && bus.rd_ready;
    // A full FIFO still takes the word when the consumer frees a slot this cycle
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    assign bus.rd_valid = fifo_valid;
    assign bus.rd_data  = fifo_data;

    medidor_desempenho_oci_sync_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .wdata    (entry),
        .rd_ready (bus.rd_ready),
        .rd_data  (fifo_data),
        .rd_valid (fifo_valid),
        .level    (level),
        .full     (full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            test_has_ended <= 1'b0;
            overflow       <= 1'b0;
            drop_count     <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
            end
            case (state)
                RUN: begin
                    if (test_ending) state <= FLUSH;
                end
                FLUSH: begin
                    // Nothing is pushed while flushing, so this is exactly "level becomes 0"
                    if (level == '0 || (level == LVL_W'(1) && pop)) begin
                        state          <= DONE;
                        test_has_ended <= 1'b1;
                    end
                end
                DONE: begin
                    if (restart) begin
                        state          <= RUN;
                        test_has_ended <= 1'b0;
                        overflow       <= 1'b0;
                        drop_count     <= '0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_blk_d45685.sv
// tb/tb_blk_d45685.sv - directed and random checks of blk_d45685 against a queue-based model
module tb_blk_d45685;
    import medidor_desempenho_oci_pkg::*;

    localparam int DEPTH  = 16;
    localparam int DROP_W = 16;
    localparam int LVL_W  = $clog2(DEPTH) + 1;
`ifdef MEDIDOR_OCI_TRACE_TSTAMP_EN
    localparam int ENTRY_W = entry_width(DCT_W_DEF, CNT_W_DEF, TS_W_DEF, 1'b1);
`else
    localparam int ENTRY_W = entry_width(DCT_W_DEF, CNT_W_DEF, TS_W_DEF, 1'b0);
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              test_ending;
    logic              restart;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;
    logic              test_has_ended;

    blk_d45685_if #(.DCT_W(DCT_W_DEF), .CNT_W(CNT_W_DEF), .ENTRY_W(ENTRY_W)) bus ();

    blk_d45685 #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .test_ending    (test_ending),
        .restart        (restart),
        .level          (level),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: 0 = capturing, 1 = draining, 2 = finished
    logic [ENTRY_W-1:0] mq[$];
    int          mstate;
    bit          movf;
    int          mdrop;
    int unsigned mts;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit rs, input bit v, input logic [29:0] b, input logic [3:0] c,
                              input bit rdy, input bit te, input bit rt);
        bit pop, cap;
        int old;
        if (rs) begin
            mq.delete();
            mstate = 0; movf = 0; mdrop = 0; mts = 0;
            return;
        end
        old = mstate;
        pop = (mq.size() > 0) && rdy;
        cap = (mstate == 0) && v && (c != 0);
        if (pop) void'(mq.pop_front());
        if (cap) begin
            if (mq.size() < DEPTH) begin
`ifdef MEDIDOR_OCI_TRACE_TSTAMP_EN
                mq.push_back({mts[TS_W_DEF-1:0], c, b});
`else
                mq.push_back({c, b});
`endif
            end else begin
                movf = 1;
                if (mdrop != (1 << DROP_W) - 1) mdrop++;
            end
        end
        mts++;
        if (old == 0 && te) mstate = 1;
        if (old == 1 && mq.size() == 0) mstate = 2;
        if (old == 2 && rt) begin
            mstate = 0; movf = 0; mdrop = 0;
        end
    endtask

    task automatic step(input bit rs, input bit v, input logic [29:0] b, input logic [3:0] c,
                        input bit rdy, input bit te, input bit rt);
        reset = rs; bus.dct_valid = v; bus.dct_buffer = b; bus.dct_count = c;
        bus.rd_ready = rdy; test_ending = te; restart = rt;
        @(posedge clk);
        model_edge(rs, v, b, c, rdy, te, rt);
        #1;
        chk("rd_valid", 128'(bus.rd_valid), 128'(mq.size() > 0));
        if (mq.size() > 0) chk("rd_data", 128'(bus.rd_data), 128'(mq[0]));
        chk("level", 128'(level), 128'(mq.size()));
        chk("overflow", 128'(overflow), 128'(movf));
        chk("drop_count", 128'(drop_count), 128'(mdrop));
        chk("test_has_ended", 128'(test_has_ended), 128'(mstate == 2));
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, '0, '0, rdy, 0, 0);
    endtask

    task automatic push_word(input bit rdy);
        step(0, 1, 30'($urandom), 4'($urandom_range(1, 15)), rdy, 0, 0);
    endtask

    initial begin
        step(1, 0, '0, '0, 0, 0, 0);
        step(1, 0, '0, '0, 0, 0, 0);
        chk("reset rd_data", 128'(bus.rd_data), 128'(0));

        // Three words with dct_count=4, consumer always ready
        for (int i = 0; i < 3; i++) step(0, 1, 30'($urandom), 4'd4, 1, 0, 0);
        for (int i = 0; i < 3; i++) idle(1);

        // Zero-count words are ignored
        for (int i = 0; i < 3; i++) step(0, 1, 30'($urandom), 4'd0, 0, 0, 0);

        // Overfill: 20 pushes into 16 entries
        for (int i = 0; i < 20; i++) push_word(0);
        chk("full level", 128'(level), 128'(16));
        chk("four drops", 128'(drop_count), 128'(4));

        // Full with simultaneous pop: accepted, no drop
        push_word(1);
        chk("full+pop level", 128'(level), 128'(16));
        chk("full+pop drops", 128'(drop_count), 128'(4));

        // Drain with a stalling consumer
        for (int i = 0; i < 60 && mq.size() > 0; i++) idle(1'($urandom));
        for (int i = 0; i < 20 && mq.size() > 0; i++) idle(1);

        // Flush sequence, including ignored captures and ignored control pulses
        for (int i = 0; i < 5; i++) push_word(0);
        step(0, 1, 30'($urandom), 4'd3, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 30'($urandom), 4'd5, 0, 1, 1);
        for (int i = 0; i < 8; i++) step(0, 1, 30'($urandom), 4'd5, 1, 0, 0);
        chk("flush done", 128'(test_has_ended), 128'(1));
        step(0, 1, 30'($urandom), 4'd2, 1, 1, 0);
        step(0, 0, '0, '0, 1, 0, 1);
        chk("restart clears drops", 128'(drop_count), 128'(0));
        push_word(0);

        // Reset in the middle of a flush
        for (int i = 0; i < 6; i++) push_word(0);
        step(0, 0, '0, '0, 0, 1, 0);
        chk("pre-reset level", 128'(level), 128'(7));
        step(1, 0, '0, '0, 0, 0, 0);
        push_word(0);
        idle(1);

        // Timestamps of pushes at cycles 10 and 13 after reset
        step(1, 0, '0, '0, 0, 0, 0);
        for (int i = 0; i < 10; i++) idle(0);
        push_word(0);
`ifdef MEDIDOR_OCI_TRACE_TSTAMP_EN
        chk("ts 10", 128'(bus.rd_data[ENTRY_W-1 -: TS_W_DEF]), 128'(10));
`endif
        idle(0); idle(0);
        push_word(1);
`ifdef MEDIDOR_OCI_TRACE_TSTAMP_EN
        chk("ts 13", 128'(bus.rd_data[ENTRY_W-1 -: TS_W_DEF]), 128'(13));
`endif
        idle(1); idle(1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0),
                 30'($urandom),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
